lcd_text_scheduler: RTL and testbench
=====================================

# lcd_text_scheduler

- Owns a 32-character text buffer for the 16x2 SC1602 panel.
- Arbitrates buffer writes from two requesters (round-robin).
- Feeds the 4-bit LCD driver's `character` input in lockstep with the driver's `drawing` strobe, so each frame shows the buffer in order: row 0 cols 0-15, then row 1 cols 0-15.
- Sits between application logic and the LCD driver.

## Interface
Parameters:
- FILL_CHAR, 8'h20: reset value of every buffer cell and of `character`.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- wr_req_0  in  1  requester 0 write request, level; hold until ack
- wr_addr_0  in  5  requester 0 cell (0-15 row 0, 16-31 row 1)
- wr_data_0  in  8  requester 0 character code
- wr_ack_0  out  1  one-cycle pulse; the write has taken effect
- wr_req_1 / wr_addr_1 / wr_data_1 / wr_ack_1: same as port 0, for requester 1
- commit  in  1  pulse; request frame-aligned publish
- commit_done  out  1  one-cycle pulse when the commit is applied
- drawing  in  1  from LCD driver; high while one character is being sent
- character  out  8  to LCD driver; code for the current cell
- frame_start  out  1  one-cycle pulse when `pos` wraps 31->0
- pos  out  5  cell currently presented on `character`

## Operation
- Reset values: all cells, `character` = FILL_CHAR; `pos`=0. `wr_ack_*`, `commit_done`, `frame_start`, pending flag, `drawing_q` = 0. Round-robin pointer favours port 0.
- Arbitration:
  - Port n is eligible when wr_req_n=1 and wr_ack_n=0.
  - At most one write per clock.
  - If both ports are eligible, grant the port not granted last. The pointer flips on every grant.
  - The write lands at the same edge that raises wr_ack_n.
  - If req is still high in the ack cycle, the port is ineligible. It becomes eligible again the following cycle, which is a new write.
- Character advance:
  - `drawing_q` registers `drawing`. fall = drawing_q & ~drawing.
  - On a fall edge: `pos` <= pos+1 (mod 32), and `character` <= cell[pos+1].
  - If a write to cell pos+1 lands on the same edge, `character` takes the write data (forwarding).
  - When `pos` 31->0, `frame_start` pulses.
- `character` changes only on fall edges. It is stable from `drawing` rising through the driver's low-nibble cycle.
- Commit:
  - pending_next = pending | commit.
  - At a wrap edge with pending_next=1, pulse `commit_done` (same cycle as `frame_start`) and clear pending.
  - Further commits while pending are absorbed.
- Writes to any cell other than the forwarded one are visible when `pos` next reaches it.
- Reset mid-frame: everything returns to reset values. The driver is reset by the same resetn, so position stays aligned.

## Timing
- Write latency: req sampled high -> ack and write at the next edge. Worst case with contention: 2 cycles.
- `character` update: 1 cycle after the `drawing` falling edge is visible on the input.
- `commit_done`: coincident with the first `frame_start` at or after the commit cycle.
- All outputs registered. No combinational input-to-output paths.

## Configuration
- LCD_TEXT_DOUBLE_BUFFER_EN defined:
  - Requester writes go to a back buffer.
  - `character` reads the front buffer.
  - At the commit wrap edge, the front buffer <= back buffer (bulk copy, including a same-edge write), and `character` <= back cell 0.
  - Same-edge forwarding applies only to the back-to-front path at the swap.
  - Both buffers reset to FILL_CHAR.
- Undefined:
  - Single buffer; writes are visible immediately.
  - `commit` only schedules `commit_done` at the next frame boundary (a frame-sync handshake).

## Structure
- Shared package lcd_pkg holds: LCD_COLS=16, LCD_ROWS=2, LCD_CELLS=32, LCD_ADDR_W=5, and typedef lcd_char_t (logic [7:0]).
- One sub-module: lcd_rr_arbiter, a 2-way round-robin with a registered grant pointer.

## Test plan
- Reset, then 32 `drawing` pulses (high 2 cycles, low 10) -> `character`=8'h20 throughout; `frame_start` pulses once at the 32nd fall; `pos` returns to 0.
- Both ports request at once (port 0: addr 3 / 8'h41; port 1: addr 3 / 8'h42) -> port 0 acked first, port 1 next cycle; cell 3 ends at 8'h42. Next simultaneous pair -> port 1 wins.
- Port 0 writes addr 5 = 8'h5A on the same edge as the fall that moves `pos` 4->5 -> `character`=8'h5A that cycle.
- Single-buffer build, `commit` at `pos`=10 -> `commit_done` coincides with the next `frame_start`. A second `commit` at `pos`=20 is absorbed (one pulse only).
- Double-buffer build: write addr 0 = 8'h31, no commit -> frame shows 8'h20 at cell 0. Commit -> the next frame shows 8'h31 from `frame_start`.
- Assert resetn low with `pos`=17 and writes in flight -> all outputs return to reset values immediately. No ack is emitted for the aborted request.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared geometry and types for the SC1602 16x2 text path.
package lcd_pkg;

    localparam int unsigned LCD_COLS   = 16;
    localparam int unsigned LCD_ROWS   = 2;
    localparam int unsigned LCD_CELLS  = LCD_COLS * LCD_ROWS;
    localparam int unsigned LCD_ADDR_W = 5;

    typedef logic [7:0]            lcd_char_t;
    typedef logic [LCD_ADDR_W-1:0] lcd_addr_t;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter; prio_q names the port that wins a tie.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic prio_q;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || !prio_q)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else if (grant[0]) begin
            prio_q <= 1'b1;
        end else if (grant[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_text_scheduler.sv
// 32-cell text buffer feeding the LCD driver's character input in drawing order.
// Define LCD_TEXT_DOUBLE_BUFFER_EN for a back buffer published to the front at commit.
module lcd_text_scheduler
    import lcd_pkg::*;
#(
    parameter lcd_char_t FILL_CHAR = 8'h20
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      wr_req_0,
    input  lcd_addr_t wr_addr_0,
    input  lcd_char_t wr_data_0,
    output logic      wr_ack_0,
    input  logic      wr_req_1,
    input  lcd_addr_t wr_addr_1,
    input  lcd_char_t wr_data_1,
    output logic      wr_ack_1,
    input  logic      commit,
    output logic      commit_done,
    input  logic      drawing,
    output lcd_char_t character,
    output logic      frame_start,
    output lcd_addr_t pos
);

    logic [1:0] elig, grant;
    logic       wr_en;
    lcd_addr_t  wr_addr, pos_next;
    lcd_char_t  wr_data, next_char;
    logic       drawing_q, pending_q, pending_next;
    logic       fall, wrap, swap;

    // A port still showing its ack is ineligible, so a held request becomes a new write.
    assign elig = {wr_req_1 & ~wr_ack_1, wr_req_0 & ~wr_ack_0};

    lcd_rr_arbiter u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (elig),
        .grant  (grant)
    );

    assign wr_en        = |grant;
    assign wr_addr      = grant[1] ? wr_addr_1 : wr_addr_0;
    assign wr_data      = grant[1] ? wr_data_1 : wr_data_0;
    assign fall         = drawing_q & ~drawing;
    assign pos_next     = pos + 1'b1;
    assign wrap         = fall && (pos == lcd_addr_t'(LCD_CELLS - 1));
    assign pending_next = pending_q | commit;
    assign swap         = wrap & pending_next;

`ifdef LCD_TEXT_DOUBLE_BUFFER_EN
    lcd_char_t back_q  [LCD_CELLS];
    lcd_char_t front_q [LCD_CELLS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < LCD_CELLS; i++) begin
                back_q[i]  <= FILL_CHAR;
                front_q[i] <= FILL_CHAR;
            end
        end else begin
            if (wr_en) begin
                back_q[wr_addr] <= wr_data;
            end
            // Bulk publish merges a write landing on the same edge.
            if (swap) begin
                for (int unsigned i = 0; i < LCD_CELLS; i++) begin
                    front_q[i] <= (wr_en && wr_addr == lcd_addr_t'(i)) ? wr_data : back_q[i];
                end
            end
        end
    end

    always_comb begin
        next_char = front_q[pos_next];
        if (swap) begin
            next_char = (wr_en && wr_addr == '0) ? wr_data : back_q[0];
        end
    end
`else
    lcd_char_t cells_q [LCD_CELLS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < LCD_CELLS; i++) begin
                cells_q[i] <= FILL_CHAR;
            end
        end else if (wr_en) begin
            cells_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        next_char = cells_q[pos_next];
        if (wr_en && wr_addr == pos_next) begin
            next_char = wr_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drawing_q   <= 1'b0;
            pending_q   <= 1'b0;
            wr_ack_0    <= 1'b0;
            wr_ack_1    <= 1'b0;
            frame_start <= 1'b0;
            commit_done <= 1'b0;
            pos         <= '0;
            character   <= FILL_CHAR;
        end else begin
            drawing_q   <= drawing;
            pending_q   <= swap ? 1'b0 : pending_next;
            wr_ack_0    <= grant[0];
            wr_ack_1    <= grant[1];
            frame_start <= wrap;
            commit_done <= swap;
            if (fall) begin
                pos       <= pos_next;
                character <= next_char;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Directed bench for lcd_text_scheduler; follows LCD_TEXT_DOUBLE_BUFFER_EN when defined.
module tb_lcd_text_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_req_0 = 1'b0, wr_req_1 = 1'b0;
    logic [4:0] wr_addr_0 = '0, wr_addr_1 = '0;
    logic [7:0] wr_data_0 = '0, wr_data_1 = '0;
    logic       wr_ack_0, wr_ack_1;
    logic       commit = 1'b0, commit_done;
    logic       drawing = 1'b0;
    logic [7:0] character;
    logic       frame_start;
    logic [4:0] pos;

    lcd_text_scheduler #(.FILL_CHAR(8'h20)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_req_0    (wr_req_0),
        .wr_addr_0   (wr_addr_0),
        .wr_data_0   (wr_data_0),
        .wr_ack_0    (wr_ack_0),
        .wr_req_1    (wr_req_1),
        .wr_addr_1   (wr_addr_1),
        .wr_data_1   (wr_data_1),
        .wr_ack_1    (wr_ack_1),
        .commit      (commit),
        .commit_done (commit_done),
        .drawing     (drawing),
        .character   (character),
        .frame_start (frame_start),
        .pos         (pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         port;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } wr_vec_t;

    wr_vec_t    vecs [7];
    logic [7:0] exp_frame [32];
    int         exp_pos = 0;
    bit         swapped = 1'b0;
    int         n_checks = 0, n_fail = 0;
    int         fs_cnt = 0, cd_cnt = 0, cd_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] want(input int p);
`ifdef LCD_TEXT_DOUBLE_BUFFER_EN
        return swapped ? exp_frame[p] : 8'h20;
`else
        return exp_frame[p];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_start) fs_cnt++;
        if (commit_done) begin
            cd_cnt++;
            if (!frame_start) cd_bad++;
            swapped = 1'b1;
        end
    endtask

    // One driver character slot: drawing high 2 cycles, low 10.
    task automatic pulse();
        drawing = 1'b1;
        tick();
        tick();
        drawing = 1'b0;
        tick();
        exp_pos = (exp_pos + 1) % 32;
        check("pos_advance", 32'(pos), 32'(exp_pos));
        check($sformatf("char_at_%0d", exp_pos), 32'(character), 32'(want(exp_pos)));
        repeat (9) tick();
    endtask

    task automatic do_write(input bit port, input logic [4:0] a, input logic [7:0] d,
                            output int lat);
        lat = 0;
        if (port) begin
            wr_req_1 = 1'b1; wr_addr_1 = a; wr_data_1 = d;
        end else begin
            wr_req_0 = 1'b1; wr_addr_0 = a; wr_data_0 = d;
        end
        do begin
            tick();
            lat++;
        end while (!(port ? wr_ack_1 : wr_ack_0) && lat < 4);
        wr_req_0 = 1'b0;
        wr_req_1 = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, fs_pulse, ack_seen;

        vecs[0] = '{port: 1'b0, addr: 5'd0,  data: 8'h31, exp: 8'h31};
        vecs[1] = '{port: 1'b1, addr: 5'd31, data: 8'h7E, exp: 8'h7E};
        vecs[2] = '{port: 1'b0, addr: 5'd16, data: 8'h48, exp: 8'h49};
        vecs[3] = '{port: 1'b1, addr: 5'd16, data: 8'h49, exp: 8'h49};
        vecs[4] = '{port: 1'b0, addr: 5'd15, data: 8'h21, exp: 8'h21};
        vecs[5] = '{port: 1'b1, addr: 5'd10, data: 8'h4B, exp: 8'h4B};
        vecs[6] = '{port: 1'b0, addr: 5'd1,  data: 8'h55, exp: 8'h55};
        for (int i = 0; i < 32; i++) exp_frame[i] = 8'h20;

        // Reset state
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        check("reset_pos", 32'(pos), 32'd0);
        check("reset_char", 32'(character), 32'h20);
        check("reset_ack0", 32'(wr_ack_0), 32'd0);
        check("reset_ack1", 32'(wr_ack_1), 32'd0);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        check("reset_commit_done", 32'(commit_done), 32'd0);

        // Empty frame
        fs_cnt = 0;
        fs_pulse = -1;
        for (int i = 1; i <= 32; i++) begin
            lat = fs_cnt;
            pulse();
            if (fs_cnt != lat) fs_pulse = i;
        end
        check("frame_start_count", 32'(fs_cnt), 32'd1);
        check("frame_start_pulse_idx", 32'(fs_pulse), 32'd32);
        check("pos_after_frame", 32'(pos), 32'd0);

        // Contention: port 0 first, then port 1
        wr_req_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 8'h41;
        wr_req_1 = 1'b1; wr_addr_1 = 5'd3; wr_data_1 = 8'h42;
        tick();
        check("pair1_first_ack0", 32'(wr_ack_0), 32'd1);
        check("pair1_first_ack1", 32'(wr_ack_1), 32'd0);
        wr_req_0 = 1'b0;
        tick();
        check("pair1_second_ack0", 32'(wr_ack_0), 32'd0);
        check("pair1_second_ack1", 32'(wr_ack_1), 32'd1);
        wr_req_1 = 1'b0;
        tick();
        do_write(1'b0, 5'd7, 8'h37, lat);
        check("solo_latency", 32'(lat), 32'd1);
        // Last grant went to port 0, so port 1 wins this tie
        wr_req_0 = 1'b1; wr_addr_0 = 5'd8; wr_data_0 = 8'h61;
        wr_req_1 = 1'b1; wr_addr_1 = 5'd8; wr_data_1 = 8'h62;
        tick();
        check("pair2_first_ack1", 32'(wr_ack_1), 32'd1);
        check("pair2_first_ack0", 32'(wr_ack_0), 32'd0);
        wr_req_1 = 1'b0;
        tick();
        check("pair2_second_ack0", 32'(wr_ack_0), 32'd1);
        wr_req_0 = 1'b0;
        tick();
        exp_frame[3] = 8'h42;
        exp_frame[7] = 8'h37;
        exp_frame[8] = 8'h61;
        check("char_unchanged_without_fall", 32'(character), 32'h20);

        // Table-driven writes
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].port, vecs[i].addr, vecs[i].data, lat);
            check($sformatf("vec%0d_ack_latency", i), 32'(lat), 32'd1);
        end
        for (int i = 0; i < 7; i++) exp_frame[vecs[i].addr] = vecs[i].exp;

        // Same-edge write to pos+1 while pos moves 4->5
        while (exp_pos != 4) pulse();
        drawing = 1'b1;
        tick();
        tick();
        drawing = 1'b0;
        wr_req_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 8'h5A;
        tick();
        exp_pos = 5;
        check("fwd_pos", 32'(pos), 32'd5);
        check("fwd_ack0", 32'(wr_ack_0), 32'd1);
`ifdef LCD_TEXT_DOUBLE_BUFFER_EN
        check("fwd_char", 32'(character), 32'h20);
`else
        check("fwd_char", 32'(character), 32'h5A);
`endif
        wr_req_0 = 1'b0;
        exp_frame[5] = 8'h5A;
        repeat (9) tick();

        // Commit at pos 10, second absorbed at pos 20
        cd_cnt = 0;
        cd_bad = 0;
        while (exp_pos != 10) pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("no_early_commit_done", 32'(cd_cnt), 32'd0);
        while (exp_pos != 20) pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        while (exp_pos != 0) pulse();
        check("commit_done_count", 32'(cd_cnt), 32'd1);
        check("commit_done_with_frame_start", 32'(cd_bad), 32'd0);
        // Verification frame: full contents, no further commit_done
        for (int i = 0; i < 32; i++) pulse();
        check("commit_not_repeated", 32'(cd_cnt), 32'd1);

        // Reset mid-frame with requests in flight
        while (exp_pos != 17) pulse();
        check("pre_reset_pos", 32'(pos), 32'd17);
        @(posedge clk);
        #1;
        wr_req_0 = 1'b1; wr_addr_0 = 5'd2; wr_data_0 = 8'h77;
        wr_req_1 = 1'b1; wr_addr_1 = 5'd9; wr_data_1 = 8'h66;
        #2 resetn = 1'b0;
        #1;
        check("async_reset_pos", 32'(pos), 32'd0);
        check("async_reset_char", 32'(character), 32'h20);
        check("async_reset_ack0", 32'(wr_ack_0), 32'd0);
        check("async_reset_ack1", 32'(wr_ack_1), 32'd0);
        check("async_reset_frame_start", 32'(frame_start), 32'd0);
        check("async_reset_commit_done", 32'(commit_done), 32'd0);
        ack_seen = 0;
        repeat (3) begin
            tick();
            if (wr_ack_0 || wr_ack_1) ack_seen++;
        end
        wr_req_0 = 1'b0;
        wr_req_1 = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (3) begin
            tick();
            if (wr_ack_0 || wr_ack_1) ack_seen++;
        end
        check("aborted_request_no_ack", 32'(ack_seen), 32'd0);
        for (int i = 0; i < 32; i++) exp_frame[i] = 8'h20;
        exp_pos = 0;
        swapped = 1'b0;
        check("post_reset_pos", 32'(pos), 32'd0);
        for (int i = 0; i < 32; i++) pulse();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
